inst_mem_loader: RTL and testbench



---
 rtl/inst_mem_loader.sv | 94 +++++++++
 tb/tb_inst_mem_loader.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/inst_mem_loader.sv
// Instruction memory responder for the CPU fetch port, filled by a valid/ready program-load stream.
// Fetches are combinational and served only in RUN; a stall is held while a load is pending or running.
module inst_mem_loader #(
  parameter int          ADDR_W     = 10,
  parameter logic [31:0] RESET_INST = 32'h00000000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ce,
  input  logic [31:0]       addr,
  output logic [31:0]       inst,
  output logic              stallreq,
  input  logic              load_start,
  input  logic [ADDR_W-1:0] load_len,
  input  logic [31:0]       load_data,
  input  logic              load_valid,
  output logic              load_ready,
  output logic              load_done
);

  typedef enum logic [1:0] {IDLE, LOAD, RUN} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] wptr_q, wptr_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;
  logic              done_q, done_d;
  logic [31:0]       mem_q [2**ADDR_W];

  logic              accept;
  logic [ADDR_W:0]   len_full;
  logic              fetch_hit;
  logic              unused_addr;

  // A zero length field encodes a full-memory load.
  assign len_full = (load_len == '0) ? {1'b1, {ADDR_W{1'b0}}} : {1'b0, load_len};
  assign accept   = load_valid & load_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      wptr_q  <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      wptr_q  <= wptr_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  // Memory has no reset so a reset mid-load keeps whatever was already written.
  always_ff @(posedge clk) begin
    if (accept) mem_q[wptr_q] <= load_data;
  end

  always_comb begin
    state_d = state_q;
    wptr_d  = wptr_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE, RUN: begin
        if (load_start) begin
          state_d = LOAD;
          wptr_d  = '0;
          cnt_d   = len_full;
        end
      end
      LOAD: begin
        if (accept) begin
          wptr_d = wptr_q + 1'b1;
          cnt_d  = cnt_q - 1'b1;
          if (cnt_q == {{ADDR_W{1'b0}}, 1'b1}) begin
            state_d = RUN;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    load_ready = (state_q == LOAD);
    stallreq   = (state_q != RUN);
    load_done  = done_q;
  end

  assign fetch_hit   = (state_q == RUN) && ce && (addr[31:ADDR_W+2] == '0);
  assign inst        = fetch_hit ? mem_q[addr[ADDR_W+1:2]] : RESET_INST;
  assign unused_addr = ^addr[1:0];

endmodule

// File: tb/tb_inst_mem_loader.sv
// Directed bench for inst_mem_loader: load sequences plus a table of fetch vectors.
module tb_inst_mem_loader;
  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          rst;
  logic          ce;
  logic [31:0]   addr;
  logic [31:0]   inst;
  logic          stallreq;
  logic          load_start;
  logic [AW-1:0] load_len;
  logic [31:0]   load_data;
  logic          load_valid;
  logic          load_ready;
  logic          load_done;

  inst_mem_loader #(.ADDR_W(AW), .RESET_INST(32'h00000000)) dut (
    .clk(clk), .rst(rst), .ce(ce), .addr(addr), .inst(inst), .stallreq(stallreq),
    .load_start(load_start), .load_len(load_len), .load_data(load_data),
    .load_valid(load_valid), .load_ready(load_ready), .load_done(load_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        ce;
    logic [31:0] addr;
    logic [31:0] exp;
  } vec_t;

  int          checks = 0;
  int          failures = 0;
  int          done_cnt = 0;
  logic [31:0] ld_data [1024];
  int          vpat [7] = '{1, 0, 0, 1, 1, 0, 1};
  vec_t        tbl [8];

  always @(negedge clk) if (load_done) done_cnt++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fetch(input string name, input logic c, input logic [31:0] a, input logic [31:0] exp);
    ce = c; addr = a; #1;
    chk(name, inst, exp);
  endtask

  // Runs one load of n words from ld_data; gaps applies the valid pattern,
  // poke drives a spurious load_start mid-load, w0 is the expected fetch of word 0
  // in the load_start cycle when starting from RUN.
  task automatic do_load(input logic [AW-1:0] len, input int n, input bit gaps,
                         input bit poke, input bit from_run, input logic [31:0] w0);
    int i, cyc, d0;
    @(negedge clk);
    load_start = 1'b1; load_len = len; ce = 1'b1; addr = 32'h0; #1;
    if (from_run) begin
      chk("start_cycle_fetch", inst, w0);
      chk("start_cycle_stall", {31'b0, stallreq}, 32'd0);
    end
    @(negedge clk);
    load_start = 1'b0;
    d0 = done_cnt; i = 0; cyc = 0;
    #1 chk("load_stall", {31'b0, stallreq}, 32'd1);
    chk("load_inst_blocked", inst, 32'h0);
    while (i < n && cyc < 4000) begin
      load_valid = gaps ? vpat[cyc % 7][0] : 1'b1;
      load_data  = ld_data[i];
      load_start = poke && (cyc == 1);
      load_len   = AW'(2);
      #1;
      chk("load_ready", {31'b0, load_ready}, 32'd1);
      if (load_done) chk("early_done", 32'd1, 32'd0);
      @(posedge clk);
      if (load_valid) i++;
      cyc++;
      @(negedge clk);
      load_start = 1'b0;
    end
    load_valid = 1'b0;
    if (cyc >= 4000) chk("load_timeout", 32'd1, 32'd0);
    #1;
    chk("done_pulse", {31'b0, load_done}, 32'd1);
    chk("run_stall", {31'b0, stallreq}, 32'd0);
    chk("run_ready", {31'b0, load_ready}, 32'd0);
    @(negedge clk); #1;
    chk("done_low", {31'b0, load_done}, 32'd0);
    chk("done_count", done_cnt - d0, 32'd1);
  endtask

  initial begin
    rst = 1'b1; ce = 1'b1; addr = 32'h0; load_start = 1'b0; load_len = '0;
    load_data = '0; load_valid = 1'b0;
    #1;
    chk("rst_inst", inst, 32'h0);
    chk("rst_stall", {31'b0, stallreq}, 32'd1);
    chk("rst_ready", {31'b0, load_ready}, 32'd0);
    chk("rst_done", {31'b0, load_done}, 32'd0);
    @(negedge clk); @(negedge clk); rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk); #1;
      chk("idle_inst", inst, 32'h0);
      chk("idle_stall", {31'b0, stallreq}, 32'd1);
      chk("idle_ready", {31'b0, load_ready}, 32'd0);
      chk("idle_done", {31'b0, load_done}, 32'd0);
    end

    // Basic load, then fetch table.
    ld_data[0] = 32'h34011100; ld_data[1] = 32'h34020020;
    ld_data[2] = 32'h3403ff00; ld_data[3] = 32'h3404ffff;
    do_load(AW'(4), 4, 1'b0, 1'b0, 1'b0, 32'h0);
    tbl[0] = '{1'b1, 32'h0,        32'h34011100};
    tbl[1] = '{1'b1, 32'h4,        32'h34020020};
    tbl[2] = '{1'b1, 32'h8,        32'h3403ff00};
    tbl[3] = '{1'b1, 32'hC,        32'h3404ffff};
    tbl[4] = '{1'b0, 32'h4,        32'h0};
    tbl[5] = '{1'b1, 32'h6,        32'h34020020};
    tbl[6] = '{1'b1, 32'h1000,     32'h0};
    tbl[7] = '{1'b1, 32'h80000008, 32'h0};
    for (int k = 0; k < 8; k++) begin
      fetch($sformatf("tbl%0d", k), tbl[k].ce, tbl[k].addr, tbl[k].exp);
      chk($sformatf("tbl%0d_stall", k), {31'b0, stallreq}, 32'd0);
    end

    // Gapped reload from RUN with a spurious load_start mid-load.
    for (int k = 0; k < 4; k++) ld_data[k] = 32'hA0000000 + k;
    do_load(AW'(4), 4, 1'b1, 1'b1, 1'b1, 32'h34011100);
    for (int k = 0; k < 4; k++)
      fetch($sformatf("gap_w%0d", k), 1'b1, 32'(k * 4), 32'hA0000000 + k);

    // Reset after 2 of 4 words, then a fresh 2-word load restarts at word 0.
    @(negedge clk);
    load_start = 1'b1; load_len = AW'(4);
    @(negedge clk);
    load_start = 1'b0; load_valid = 1'b1;
    for (int k = 0; k < 2; k++) begin
      load_data = 32'hC0000000 + k;
      @(negedge clk);
    end
    rst = 1'b1; load_valid = 1'b0; ce = 1'b1; addr = 32'h0; #1;
    chk("midrst_inst", inst, 32'h0);
    chk("midrst_stall", {31'b0, stallreq}, 32'd1);
    chk("midrst_ready", {31'b0, load_ready}, 32'd0);
    @(negedge clk); rst = 1'b0;
    @(negedge clk); #1;
    chk("midrst_idle_stall", {31'b0, stallreq}, 32'd1);
    ld_data[0] = 32'hD0000000; ld_data[1] = 32'hD0000001;
    do_load(AW'(2), 2, 1'b0, 1'b0, 1'b0, 32'h0);
    fetch("rl_w0", 1'b1, 32'h0, 32'hD0000000);
    fetch("rl_w1", 1'b1, 32'h4, 32'hD0000001);
    fetch("rl_w2", 1'b1, 32'h8, 32'hA0000002);
    fetch("rl_w3", 1'b1, 32'hC, 32'hA0000003);

    // Single-word reload from RUN.
    ld_data[0] = 32'hDEADBEEF;
    do_load(AW'(1), 1, 1'b0, 1'b0, 1'b1, 32'hD0000000);
    fetch("one_w0", 1'b1, 32'h0, 32'hDEADBEEF);
    fetch("one_w1", 1'b1, 32'h4, 32'hD0000001);

    // Full-depth load via load_len = 0.
    for (int k = 0; k < 1024; k++) ld_data[k] = 32'(k);
    do_load(AW'(0), 1024, 1'b0, 1'b0, 1'b1, 32'hDEADBEEF);
    fetch("full_last", 1'b1, 32'hFFC, 32'd1023);
    fetch("full_first", 1'b1, 32'h0, 32'd0);
    fetch("full_oor", 1'b1, 32'h1000, 32'h0);
    fetch("full_misalign", 1'b1, 32'h6, 32'd1);
    fetch("full_mid", 1'b1, 32'h803, 32'd512);
    fetch("full_ce0", 1'b0, 32'hFFC, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
